// File: rtl/inst_rom_ld_if.sv
// Loader bus for inst_rom_ld: byte stream in, status and counters out.
// ADDR_W must match the ADDR_W of the attached inst_rom_ld.
interface inst_rom_ld_if #(
  parameter int unsigned ADDR_W = 10
) ();
  logic              ld_valid_i;
  logic [7:0]        ld_byte_i;
  logic              ld_last_i;
  logic              ld_clr_i;
  logic              ld_ready_o;
  logic              ld_done_o;
  logic              ld_ovf_o;
  logic [ADDR_W:0]   ld_words_o;
  logic [31:0]       ld_sum_o;

  modport master (
    output ld_valid_i, ld_byte_i, ld_last_i, ld_clr_i,
    input  ld_ready_o, ld_done_o, ld_ovf_o, ld_words_o, ld_sum_o
  );

  modport slave (
    input  ld_valid_i, ld_byte_i, ld_last_i, ld_clr_i,
    output ld_ready_o, ld_done_o, ld_ovf_o, ld_words_o, ld_sum_o
  );
endinterface

// File: rtl/inst_rom_ld.sv
// Instruction ROM filled by a big-endian byte loader, then read combinationally by the core.
// Optional macro ROM_CHKSUM_EN adds a running modulo-2^32 sum of written words on ld_sum_o.
module inst_rom_ld #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  inst_rom_ld_if.slave       ld,
  input  logic               ce,
  input  logic [31:0]        addr,
  output logic [31:0]        inst
);

  localparam int unsigned Depth = 1 << ADDR_W;
  localparam logic        LOAD  = 1'b0;
  localparam logic        DONE  = 1'b1;

  logic              r_state;
  logic [1:0]        r_bcnt;
  logic [31:0]       r_part;
  logic [ADDR_W:0]   r_words;
  logic              r_ovf;
  logic [31:0]       r_mem [Depth];

  logic              w_ready;
  logic              w_acc;
  logic              w_wr;
  logic              w_we;
  logic              w_full;
  logic [31:0]       w_asm;
  logic [ADDR_W-1:0] w_wr_idx;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_unused_addr;

  assign w_ready  = (r_state == LOAD) && !ld.ld_clr_i;
  assign w_acc    = ld.ld_valid_i && w_ready;
  assign w_wr     = w_acc && ((r_bcnt == 2'd3) || ld.ld_last_i);
  assign w_we     = rst && w_wr;
  assign w_wr_idx = r_words[ADDR_W-1:0];
  assign w_full   = (w_wr_idx == {ADDR_W{1'b1}});

  // Earlier bytes sit in r_part at their final lanes; lanes below the new byte are zero.
  always_comb begin
    w_asm = 32'h0;
    unique case (r_bcnt)
      2'd0: w_asm = {ld.ld_byte_i, 24'h0};
      2'd1: w_asm = {r_part[31:24], ld.ld_byte_i, 16'h0};
      2'd2: w_asm = {r_part[31:16], ld.ld_byte_i, 8'h0};
      2'd3: w_asm = {r_part[31:8], ld.ld_byte_i};
      default: w_asm = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= LOAD;
      r_bcnt  <= 2'd0;
      r_part  <= 32'h0;
      r_words <= '0;
      r_ovf   <= 1'b0;
    end else if (ld.ld_clr_i) begin
      r_state <= LOAD;
      r_bcnt  <= 2'd0;
      r_part  <= 32'h0;
      r_words <= '0;
      r_ovf   <= 1'b0;
    end else if (w_acc) begin
      r_part <= w_asm;
      if (w_wr) begin
        r_bcnt  <= 2'd0;
        r_words <= r_words + 1'b1;
        if (w_full || ld.ld_last_i) r_state <= DONE;
        if (w_full && !ld.ld_last_i) r_ovf <= 1'b1;
      end else begin
        r_bcnt <= r_bcnt + 2'd1;
      end
    end
  end

  // Contents are never reset; the read mask below hides stale words.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_wr_idx] <= w_asm;
  end

`ifdef ROM_CHKSUM_EN
  logic [31:0] r_sum;

  always_ff @(posedge clk) begin
    if (!rst || ld.ld_clr_i) begin
      r_sum <= 32'h0;
    end else if (w_wr) begin
      r_sum <= r_sum + w_asm;
    end
  end

  assign ld.ld_sum_o = r_sum;
`else
  assign ld.ld_sum_o = 32'h0;
`endif

  assign w_rd_idx      = addr[ADDR_W+1:2];
  assign w_unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  always_comb begin
    inst = 32'h0;
    if (ce && (r_state == DONE) && ({1'b0, w_rd_idx} < r_words)) inst = r_mem[w_rd_idx];
  end

  assign ld.ld_ready_o = w_ready;
  assign ld.ld_done_o  = (r_state == DONE);
  assign ld.ld_ovf_o   = r_ovf;
  assign ld.ld_words_o = r_words;

endmodule

// File: tb/tb_inst_rom_ld.sv
// Directed bench for inst_rom_ld: a default-size instance and a 4-word instance for overflow.
module tb_inst_rom_ld;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] inst;
  logic [31:0] inst2;
  int          errors;
  int          checks;

  inst_rom_ld_if #(.ADDR_W(10)) ld ();
  inst_rom_ld_if #(.ADDR_W(2))  ld2 ();

  inst_rom_ld #(.ADDR_W(10)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld.slave),
    .ce   (ce),
    .addr (addr),
    .inst (inst)
  );

  inst_rom_ld #(.ADDR_W(2)) u_dut2 (
    .clk  (clk),
    .rst  (rst),
    .ld   (ld2.slave),
    .ce   (ce),
    .addr (addr),
    .inst (inst2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    ld.ld_valid_i = 1'b1;
    ld.ld_byte_i  = b;
    ld.ld_last_i  = last;
    tick();
    ld.ld_valid_i = 1'b0;
    ld.ld_last_i  = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b, input logic last);
    ld2.ld_valid_i = 1'b1;
    ld2.ld_byte_i  = b;
    ld2.ld_last_i  = last;
    tick();
    ld2.ld_valid_i = 1'b0;
    ld2.ld_last_i  = 1'b0;
  endtask

  task automatic clear();
    ld.ld_clr_i = 1'b1;
    tick();
    ld.ld_clr_i = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, {32'h0, inst}, {32'h0, exp});
  endtask

  initial begin
    logic [31:0] exp_sum;
    errors = 0;
    checks = 0;
    rst = 1'b0;
    ce  = 1'b1;
    addr = 32'h0;
    ld.ld_valid_i = 1'b0; ld.ld_byte_i = 8'h0; ld.ld_last_i = 1'b0; ld.ld_clr_i = 1'b0;
    ld2.ld_valid_i = 1'b0; ld2.ld_byte_i = 8'h0; ld2.ld_last_i = 1'b0; ld2.ld_clr_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // Reset state
    chk("rst_ready", {63'h0, ld.ld_ready_o}, 64'h1);
    chk("rst_done", {63'h0, ld.ld_done_o}, 64'h0);
    chk("rst_ovf", {63'h0, ld.ld_ovf_o}, 64'h0);
    chk("rst_words", {53'h0, ld.ld_words_o}, 64'h0);
    chk("rst_sum", {32'h0, ld.ld_sum_o}, 64'h0);
    rd("rst_inst", 32'h0, 32'h0);

    // Two full words, last on the 8th byte
    send(8'h34, 1'b0); send(8'h01, 1'b0); send(8'h00, 1'b0); send(8'h0A, 1'b0);
    send(8'h8C, 1'b0); send(8'h22, 1'b0); send(8'h00, 1'b0);
    chk("two_notdone", {63'h0, ld.ld_done_o}, 64'h0);
    chk("two_words_mid", {53'h0, ld.ld_words_o}, 64'h1);
    send(8'h04, 1'b1);
    chk("two_words", {53'h0, ld.ld_words_o}, 64'h2);
    chk("two_done", {63'h0, ld.ld_done_o}, 64'h1);
    chk("two_ready", {63'h0, ld.ld_ready_o}, 64'h0);
    rd("two_rd0", 32'h0, 32'h3401000A);
    rd("two_rd4", 32'h4, 32'h8C220004);
    rd("two_rd8", 32'h8, 32'h0);
    rd("two_rd_hi", 32'hFFFF_F007, 32'h8C220004);
`ifdef ROM_CHKSUM_EN
    exp_sum = 32'hC023000E;
`else
    exp_sum = 32'h0;
`endif
    chk("two_sum", {32'h0, ld.ld_sum_o}, {32'h0, exp_sum});
    ce = 1'b0;
    rd("two_ce0", 32'h0, 32'h0);
    ce = 1'b1;
    send(8'hEE, 1'b1);
    chk("done_ignore", {53'h0, ld.ld_words_o}, 64'h2);

    // Clear from DONE, then a partial final word
    ld.ld_clr_i = 1'b1;
    #1;
    chk("clr_ready", {63'h0, ld.ld_ready_o}, 64'h0);
    tick();
    ld.ld_clr_i = 1'b0;
    chk("clr_done", {63'h0, ld.ld_done_o}, 64'h0);
    chk("clr_words", {53'h0, ld.ld_words_o}, 64'h0);
    chk("clr_sum", {32'h0, ld.ld_sum_o}, 64'h0);
    rd("load_inst", 32'h0, 32'h0);
    send(8'hAB, 1'b0); send(8'hCD, 1'b0); send(8'hEF, 1'b1);
    chk("part_words", {53'h0, ld.ld_words_o}, 64'h1);
    chk("part_done", {63'h0, ld.ld_done_o}, 64'h1);
    rd("part_rd0", 32'h0, 32'hABCDEF00);
    rd("part_rd4", 32'h4, 32'h0);

    // Clear wins over a concurrent byte in LOAD
    clear();
    ld.ld_clr_i = 1'b1; ld.ld_valid_i = 1'b1; ld.ld_byte_i = 8'h55;
    #1;
    chk("clrv_ready", {63'h0, ld.ld_ready_o}, 64'h0);
    tick();
    ld.ld_clr_i = 1'b0; ld.ld_valid_i = 1'b0;
    chk("clrv_words", {53'h0, ld.ld_words_o}, 64'h0);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    chk("clrv_notdone", {63'h0, ld.ld_done_o}, 64'h0);
    send(8'h05, 1'b1);
    chk("clrv_words2", {53'h0, ld.ld_words_o}, 64'h2);
    rd("clrv_rd0", 32'h0, 32'h01020304);
    rd("clrv_rd4", 32'h4, 32'h05000000);

    // Reset mid-word discards the partial word and overrides a concurrent byte
    clear();
    send(8'hAA, 1'b0); send(8'hBB, 1'b0);
    rst = 1'b0; ld.ld_valid_i = 1'b1; ld.ld_byte_i = 8'h99; ld.ld_clr_i = 1'b1;
    tick();
    rst = 1'b1; ld.ld_valid_i = 1'b0; ld.ld_clr_i = 1'b0;
    chk("mrst_words", {53'h0, ld.ld_words_o}, 64'h0);
    chk("mrst_done", {63'h0, ld.ld_done_o}, 64'h0);
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
    chk("mrst_words2", {53'h0, ld.ld_words_o}, 64'h1);
    rd("mrst_rd0", 32'h0, 32'h11223344);
`ifdef ROM_CHKSUM_EN
    exp_sum = 32'h11223344;
`else
    exp_sum = 32'h0;
`endif
    chk("mrst_sum", {32'h0, ld.ld_sum_o}, {32'h0, exp_sum});

    // Overflow on the 4-word instance
    for (int i = 0; i < 15; i++) send2(8'(i), 1'b0);
    chk("ovf_notdone", {63'h0, ld2.ld_done_o}, 64'h0);
    chk("ovf_pre", {63'h0, ld2.ld_ovf_o}, 64'h0);
    send2(8'h0F, 1'b0);
    chk("ovf_done", {63'h0, ld2.ld_done_o}, 64'h1);
    chk("ovf_flag", {63'h0, ld2.ld_ovf_o}, 64'h1);
    chk("ovf_words", {61'h0, ld2.ld_words_o}, 64'h4);
    send2(8'h10, 1'b0);
    chk("ovf_17th", {61'h0, ld2.ld_words_o}, 64'h4);
    addr = 32'hC;
    #1;
    chk("ovf_rd12", {32'h0, inst2}, 64'h0C0D0E0F);
    addr = 32'h10;
    #1;
    chk("ovf_rd_wrap", {32'h0, inst2}, 64'h00010203);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
